mem_access_unit: RTL

Memory stage that sits directly downstream of the execute-stage ALU. It takes the ALU's computed effective address, the rt store data and a decoded memory opcode, and runs a request/acknowledge transaction on the data-memory port. It also generates byte enables, lane-aligns load data with sign or zero extension, and presents a one-cycle writeback. It stalls the pipeline while a transaction is in flight and flags misaligned accesses instead of issuing them.

---
 rtl/mem_pkg.sv | 96 +++++++++
 rtl/load_align.sv | 36 +++
 rtl/mem_access_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the memory-access stage: memory opcode encodings,
// FSM state encodings, access width classes and small decode helpers used by
// both the control path and the load aligner.
package mem_pkg;

  // Memory opcodes as decoded upstream.
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB       = 4'd1,
    LBU      = 4'd2,
    LH       = 4'd3,
    LHU      = 4'd4,
    LW       = 4'd5,
    SB       = 4'd6,
    SH       = 4'd7,
    SW       = 4'd8
  } mem_op_e;

  // Transaction FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mem_state_e;

  // Access width classes. WC_NONE also covers unused opcode values,
  // so those opcodes are never accepted as memory ops.
  typedef enum logic [1:0] {
    WC_NONE = 2'd0,
    WC_BYTE = 2'd1,
    WC_HALF = 2'd2,
    WC_WORD = 2'd3
  } width_class_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic width_class_e op_width(input mem_op_e op);
    width_class_e wc;
    case (op)
      LB, LBU, SB: wc = WC_BYTE;
      LH, LHU, SH: wc = WC_HALF;
      LW, SW:      wc = WC_WORD;
      default:     wc = WC_NONE;
    endcase
    return wc;
  endfunction

  function automatic logic op_is_load(input mem_op_e op);
    return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
  endfunction

  function automatic logic op_is_store(input mem_op_e op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Bytes never misalign; halves need bit 0 clear, words both low bits clear.
  function automatic logic op_aligned(input mem_op_e op, input logic [1:0] addr_lo);
    logic ok;
    case (op_width(op))
      WC_BYTE: ok = 1'b1;
      WC_HALF: ok = ~addr_lo[0];
      WC_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Little-endian lane enables; loads use the same enables as stores.
  function automatic logic [3:0] op_byte_en(input mem_op_e op, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (op_width(op))
      WC_BYTE: be = 4'b0001 << addr_lo;
      WC_HALF: be = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
      WC_WORD: be = BE_WORD;
      default: be = BE_NONE;
    endcase
    return be;
  endfunction

  // Store data is replicated across lanes so the slave only needs the enables.
  function automatic logic [31:0] op_store_lanes(input mem_op_e op, input logic [31:0] data);
    logic [31:0] lanes;
    case (op)
      SB:      lanes = {4{data[7:0]}};
      SH:      lanes = {2{data[15:0]}};
      SW:      lanes = data;
      default: lanes = 32'h0;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align
// Combinational load-data aligner. Picks the addressed byte or halfword
// lane from the read word and sign- or zero-extends it to 32 bits.
// Ports:
//   i_rdata  : raw 32-bit word from data memory
//   i_addrLo : low two address bits of the access
//   i_op     : memory opcode (non-load opcodes give zero)
//   o_data   : extended load value
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addrLo,
  input  mem_op_e     i_op,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addrLo, 3'b000} +: 8];
  assign w_half = i_addrLo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = 32'h0;
    case (i_op)
      LB:      o_data = {{24{w_byte[7]}}, w_byte};
      LBU:     o_data = {24'h0, w_byte};
      LH:      o_data = {{16{w_half[15]}}, w_half};
      LHU:     o_data = {16'h0, w_half};
      LW:      o_data = i_rdata;
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory pipeline stage. Accepts a memory op from EX, checks alignment,
// runs one req/ack transaction on the data-memory port, and produces a
// one-cycle load writeback. Misaligned ops raise a one-cycle addr_err and
// are never issued.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   ex_valid, mem_op, addr,
//   store_data, rd_in          : instruction presented by EX
//   stall                      : freezes upstream while the op is accepted/in flight
//   dmem_req/we/addr/be/wdata  : data-memory request, held stable until dmem_ack
//   dmem_ack, dmem_rdata       : slave completion and read word
//   wb_valid, wb_rd, wb_data   : registered one-cycle load writeback
//   addr_err                   : registered one-cycle misalignment pulse
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DMEM_AW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  input  logic [3:0]         mem_op,
  input  logic [31:0]        addr,
  input  logic [31:0]        store_data,
  input  logic [4:0]         rd_in,
  output logic               stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_ack,
  input  logic [31:0]        dmem_rdata,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               addr_err
);

  mem_state_e  r_state;
  mem_state_e  w_nextState;
  mem_op_e     r_op;
  logic [31:0] r_addr;
  logic [31:0] r_storeData;
  logic [4:0]  r_rd;
  logic        r_wbValid;
  logic [4:0]  r_wbRd;
  logic [31:0] r_wbData;
  logic        r_addrErr;

  mem_op_e     w_op;
  logic        w_stall;
  logic        w_latch;
  logic        w_misalign;
  logic        w_capture;
  logic        w_inAccess;
  logic        w_rIsLoad;
  logic        w_rIsStore;
  logic [31:0] w_loadData;

  assign w_op       = mem_op_e'(mem_op);
  assign w_inAccess = (r_state == ST_ACCESS);
  assign w_rIsLoad  = op_is_load(r_op);
  assign w_rIsStore = op_is_store(r_op);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control strobes. Only IDLE looks at EX; an op that
  // fails alignment is dropped here and only reported through addr_err.
  always_comb begin
    w_nextState = r_state;
    w_stall     = 1'b0;
    w_latch     = 1'b0;
    w_misalign  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ex_valid && (op_width(w_op) != WC_NONE)) begin
          if (op_aligned(w_op, addr[1:0])) begin
            w_latch     = 1'b1;
            w_stall     = 1'b1;
            w_nextState = ST_ACCESS;
          end else begin
            w_misalign = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        w_stall = 1'b1;
        if (dmem_ack) begin
          w_capture   = 1'b1;
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Request context latched on accept, plus the registered writeback and
  // error pulses. wb_rd/wb_data read zero outside their one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= MEM_NONE;
      r_addr      <= 32'h0;
      r_storeData <= 32'h0;
      r_rd        <= 5'd0;
      r_wbValid   <= 1'b0;
      r_wbRd      <= 5'd0;
      r_wbData    <= 32'h0;
      r_addrErr   <= 1'b0;
    end else begin
      r_addrErr <= w_misalign;
      r_wbValid <= w_capture && w_rIsLoad;
      if (w_capture && w_rIsLoad) begin
        r_wbRd   <= r_rd;
        r_wbData <= w_loadData;
      end else begin
        r_wbRd   <= 5'd0;
        r_wbData <= 32'h0;
      end
      if (w_latch) begin
        r_op        <= w_op;
        r_addr      <= addr;
        r_storeData <= store_data;
        r_rd        <= rd_in;
      end
    end
  end

  load_align u_loadAlign (
    .i_rdata  (dmem_rdata),
    .i_addrLo (r_addr[1:0]),
    .i_op     (r_op),
    .o_data   (w_loadData)
  );

  // The port is driven only in ACCESS so that a reset drops everything at once
  // and the bus is quiet while idle.
  assign stall      = w_stall;
  assign dmem_req   = w_inAccess;
  assign dmem_we    = w_inAccess && w_rIsStore;
  assign dmem_addr  = w_inAccess ? DMEM_AW'({r_addr[31:2], 2'b00}) : '0;
  assign dmem_be    = w_inAccess ? op_byte_en(r_op, r_addr[1:0]) : BE_NONE;
  assign dmem_wdata = (w_inAccess && w_rIsStore) ? op_store_lanes(r_op, r_storeData) : 32'h0;
  assign wb_valid   = r_wbValid;
  assign wb_rd      = r_wbRd;
  assign wb_data    = r_wbData;
  assign addr_err   = r_addrErr;

endmodule
